// File: rtl/mem_access_pkg.sv
// Shared types, transfer-size constants and legality helpers for the memory-stage access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  // Size must be a supported power of two no wider than the data bus.
  function automatic logic size_legal(input logic [3:0] size, input int unsigned max_bytes);
    return ((size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D)) &&
           (32'(size) <= max_bytes);
  endfunction

  // Only meaningful for power-of-two sizes; other sizes are already rejected by size_legal.
  function automatic logic addr_aligned(input logic [3:0] addr_lo, input logic [3:0] size);
    return (addr_lo & (size - 4'd1)) == 4'd0;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bus between the access unit (master) and the data memory (slave).
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
);
  logic              m_req_valid;
  logic              m_req_ready;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [3:0]        m_size;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rsp_valid;
  logic [DATA_W-1:0] m_rsp_data;

  modport master (
    output m_req_valid, m_addr, m_we, m_size, m_wdata,
    input  m_req_ready, m_rsp_valid, m_rsp_data
  );

  modport slave (
    input  m_req_valid, m_addr, m_we, m_size, m_wdata,
    output m_req_ready, m_rsp_valid, m_rsp_data
  );
endinterface

// File: rtl/mem_load_extend.sv
// Combinational sign/zero extension of a right-justified sub-word load to the full data width.
module mem_load_extend
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        size,
  input  logic              signed_en,
  output logic [DATA_W-1:0] out
);

  int   nbits;
  logic fill;

  always_comb begin
    nbits = int'(DATA_W);
    fill  = 1'b0;
    out   = '0;
    case (size)
      SZ_B:    begin nbits = 8;  fill = data[7];  end
      SZ_H:    begin nbits = 16; fill = data[15]; end
      SZ_W:    begin nbits = 32; fill = data[31]; end
      default: begin nbits = int'(DATA_W); fill = 1'b0; end
    endcase
    fill = fill & signed_en;
    for (int i = 0; i < int'(DATA_W); i++) begin
      out[i] = (i < nbits) ? data[i] : fill;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: stalls the pipeline across a variable-latency request/response
// access, checks alignment/legality, extends sub-word loads and faults on response timeout.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic [3:0]        xfer_size,
  input  logic              load_signed,
  output logic              stall,
  output logic              done,
  output logic              fault,
  output logic [DATA_W-1:0] load_data,
  mem_access_unit_if.master mem
);

  localparam int unsigned CNT_W      = $clog2(MAX_WAIT + 1);
  localparam int unsigned DATA_BYTES = DATA_W / 8;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              signed_q, signed_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] ldata_q, ldata_d;
  logic [DATA_W-1:0] ext_data;
  logic              start, illegal;

  mem_load_extend #(.DATA_W(DATA_W)) u_extend (
    .data      (mem.m_rsp_data),
    .size      (size_q),
    .signed_en (signed_q),
    .out       (ext_data)
  );

  assign start   = mem_read | mem_write;
  assign illegal = (mem_read & mem_write) |
                   ~size_legal(xfer_size, DATA_BYTES) |
                   ~addr_aligned(address[3:0], xfer_size);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state, request latching, timeout counting and the combinational stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    signed_d = signed_q;
    fault_d  = fault_q;
    ldata_d  = ldata_q;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stall = 1'b1;
          if (illegal) begin
            state_d = DONE;
            fault_d = 1'b1;
            ldata_d = '0;
          end else begin
            state_d  = REQ;
            fault_d  = 1'b0;
            addr_d   = address;
            we_d     = mem_write;
            size_d   = xfer_size;
            wdata_d  = write_data;
            signed_d = load_signed;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem.m_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem.m_rsp_valid) begin
          state_d = DONE;
          if (!we_q) ldata_d = ext_data;
        end else if (32'(cnt_inc) == MAX_WAIT) begin
          state_d = DONE;
          fault_d = 1'b1;
          ldata_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      wdata_q  <= '0;
      signed_q <= 1'b0;
      fault_q  <= 1'b0;
      ldata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      signed_q <= signed_d;
      fault_q  <= fault_d;
      ldata_q  <= ldata_d;
    end
  end

  // Bus payload comes straight from the request latches, so it cannot change while in REQ.
  assign mem.m_req_valid = (state_q == REQ);
  assign mem.m_addr      = addr_q;
  assign mem.m_we        = we_q;
  assign mem.m_size      = size_q;
  assign mem.m_wdata     = wdata_q;

  assign done      = (state_q == DONE);
  assign fault     = done & fault_q;
  assign load_data = ldata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan accesses plus randomized ones
// checked against a transaction-level model of latency, fault and load result.
module tb_mem_access_unit;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_read, mem_write, load_signed;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [3:0]        xfer_size;
  logic              stall, done, fault;
  logic [DATA_W-1:0] load_data;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] model_ld = 64'd0;

  mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .address     (address),
    .write_data  (write_data),
    .xfer_size   (xfer_size),
    .load_signed (load_signed),
    .stall       (stall),
    .done        (done),
    .fault       (fault),
    .load_data   (load_data),
    .mem         (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference extension: mask to 8*size bits, then sign-fill from the top kept bit if requested.
  function automatic logic [63:0] ext_model(input logic [63:0] d, input int sz, input bit sgn);
    logic [127:0] mask;
    logic [127:0] v;
    mask = (128'd1 << (8 * sz)) - 128'd1;
    v    = {64'd0, d} & mask;
    if (sgn && v[8*sz-1]) v = v | ~mask;
    return v[63:0];
  endfunction

  // One pipeline access against a memory that accepts after rdy_dly REQ cycles and
  // responds in WAIT cycle rsp_dly (negative: never).
  task automatic access(input bit rd, input bit wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [3:0] sz, input bit sgn,
                        input int rdy_dly, input int rsp_dly, input logic [63:0] rdata,
                        input string tag);
    int   szi       = int'(sz);
    bit   illegal   = (rd && wr) || !(szi == 1 || szi == 2 || szi == 4 || szi == 8) ||
                      ((addr % 64'(szi)) != 64'd0);
    bit   to_exp    = !illegal && (rsp_dly < 0 || rsp_dly >= int'(MAX_WAIT));
    int   exp_cyc   = illegal ? 1 : (to_exp ? 2 + rdy_dly + int'(MAX_WAIT) : 3 + rdy_dly + rsp_dly);
    int   exp_req   = illegal ? 0 : rdy_dly + 1;
    logic [63:0] exp_ld;
    int   nstall    = 0;
    int   nreq      = 0;
    int   w         = 0;
    int   done_cyc  = -1;
    bit   accepted  = 0;
    bit   payload_bad = 0;
    bit   done_stall = 1;
    bit   fault_seen = 0;

    if (illegal || to_exp) exp_ld = 64'd0;
    else if (rd)           exp_ld = ext_model(rdata, szi, sgn);
    else                   exp_ld = model_ld;

    @(negedge clk);
    mem_read = rd; mem_write = wr; address = addr; write_data = wdata;
    xfer_size = sz; load_signed = sgn;
    mif.m_req_ready = 1'b0; mif.m_rsp_valid = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (done) begin
        done_cyc   = cyc;
        done_stall = stall;
        fault_seen = fault;
        break;
      end
      if (stall) nstall++;
      if (mif.m_req_valid) begin
        if (mif.m_addr !== addr || mif.m_we !== wr || mif.m_size !== sz || mif.m_wdata !== wdata)
          payload_bad = 1;
        mif.m_req_ready = (nreq >= rdy_dly);
        if (nreq >= rdy_dly) accepted = 1;
        nreq++;
        mif.m_rsp_valid = 1'($urandom_range(0, 1));
        mif.m_rsp_data  = {$urandom, $urandom};
      end else if (accepted) begin
        mif.m_req_ready = 1'($urandom_range(0, 1));
        mif.m_rsp_valid = (w == rsp_dly);
        mif.m_rsp_data  = (w == rsp_dly) ? rdata : {$urandom, $urandom};
        w++;
      end else begin
        mif.m_req_ready = 1'($urandom_range(0, 1));
        mif.m_rsp_valid = 1'b0;
        mif.m_rsp_data  = {$urandom, $urandom};
      end
      @(negedge clk);
    end
    chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_cyc));
    chk({tag, "_stall_cnt"}, 64'(nstall), 64'(exp_cyc));
    chk({tag, "_req_cnt"}, 64'(nreq), 64'(exp_req));
    chk({tag, "_payload"}, 64'(payload_bad), 64'd0);
    chk({tag, "_done_stall"}, 64'(done_stall), 64'd0);
    chk({tag, "_fault"}, 64'(fault_seen), 64'(illegal || to_exp));
    chk({tag, "_ld"}, load_data, exp_ld);
    model_ld = exp_ld;

    mem_read = 1'b0; mem_write = 1'b0;
    mif.m_req_ready = 1'b0; mif.m_rsp_valid = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_pulse"}, 64'({done, fault, stall}), 64'd0);
    chk({tag, "_hold"}, load_data, model_ld);
  endtask

  initial begin
    logic [63:0] ra;
    logic [3:0]  rsz;
    int          sel;
    int          rspd;
    bit          rrd, rwr;
    logic [3:0]  sizes [6];
    sizes = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd8};

    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; load_signed = 1'b0;
    address = '0; write_data = '0; xfer_size = 4'd0;
    mif.m_req_ready = 1'b0; mif.m_rsp_valid = 1'b0; mif.m_rsp_data = '0;
    @(negedge clk); #1;
    chk("rst_outs", 64'({stall, done, fault, mif.m_req_valid, mif.m_we}), 64'd0);
    chk("rst_ld", load_data, 64'd0);
    chk("rst_addr", mif.m_addr, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Signed byte load, immediate ready and response.
    access(1, 0, 64'h1003, 64'd0, 4'd1, 1, 0, 0, 64'h1234_5678_9ABC_DE80, "lb_s");
    chk("lb_s_const", load_data, 64'hFFFF_FFFF_FFFF_FF80);
    // Same load zero-extended, two wait cycles.
    access(1, 0, 64'h1003, 64'd0, 4'd1, 0, 0, 2, 64'h1234_5678_9ABC_DE80, "lb_u");
    chk("lb_u_const", load_data, 64'h80);
    // Store double, ready after two cycles; load_data must stay 0x80.
    access(0, 1, 64'h2000, 64'hDEAD_BEEF_0123_4567, 4'd8, 0, 2, 0, 64'd0, "sd");
    chk("sd_const", load_data, 64'h80);
    // Illegal accesses: misaligned half, bad size, read+write together.
    access(1, 0, 64'h1001, 64'd0, 4'd2, 1, 0, 0, 64'hFFFF, "lh_mis");
    access(1, 0, 64'h1000, 64'd0, 4'd3, 0, 0, 0, 64'hFFFF, "sz3");
    access(1, 1, 64'h1000, 64'd0, 4'd4, 0, 0, 0, 64'hFFFF, "rdwr");
    // Half/word signed loads, then a timeout.
    access(1, 0, 64'h2002, 64'd0, 4'd2, 1, 1, 1, 64'h0000_0000_0000_8001, "lh_s");
    access(1, 0, 64'h2004, 64'd0, 4'd4, 1, 0, 3, 64'h0000_0000_8000_0001, "lw_s");
    access(1, 0, 64'h3000, 64'd0, 4'd8, 0, 1, -1, 64'h1111, "tmo");

    // A response arriving after the timeout must not touch the unit.
    mif.m_rsp_valid = 1'b1; mif.m_rsp_data = 64'hABCD;
    @(negedge clk); @(negedge clk); #1;
    chk("late_rsp_done", 64'({done, stall}), 64'd0);
    chk("late_rsp_ld", load_data, 64'd0);
    mif.m_rsp_valid = 1'b0;

    // Reset while in WAIT.
    access(1, 0, 64'h40, 64'd0, 4'd8, 0, 0, 0, 64'h5A5A_0000_1234_5678, "pre_rst");
    @(negedge clk);
    mem_read = 1'b1; address = 64'h48; xfer_size = 4'd8; mif.m_req_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("wait_stall", 64'({stall, mif.m_req_valid}), 64'b10);
    reset = 1'b1; mem_read = 1'b0; mif.m_req_ready = 1'b0;
    #1;
    chk("rst_mid_outs", 64'({stall, done, fault, mif.m_req_valid}), 64'd0);
    chk("rst_mid_ld", load_data, 64'd0);
    @(negedge clk);
    reset = 1'b0; mif.m_rsp_valid = 1'b1; mif.m_rsp_data = 64'h77;
    @(negedge clk); #1;
    chk("rst_late_rsp", 64'({done, stall}), 64'd0);
    chk("rst_late_ld", load_data, 64'd0);
    mif.m_rsp_valid = 1'b0;
    model_ld = 64'd0;
    access(1, 0, 64'h50, 64'd0, 4'd2, 1, 0, 1, 64'h0000_0000_0000_F00D, "post_rst");

    // Randomized accesses.
    for (int k = 0; k < 24; k++) begin
      sel  = int'($urandom_range(0, 9));
      rrd  = (sel <= 5);
      rwr  = (sel == 0) || (sel > 5);
      rsz  = sizes[$urandom_range(0, 5)];
      ra   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0 && rsz != 4'd0) ra = ra - (ra % 64'(rsz));
      rspd = int'($urandom_range(0, 5));
      if (rspd == 5) rspd = -1;
      access(rrd, rwr, ra, {$urandom, $urandom}, rsz, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), rspd, {$urandom, $urandom}, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
